// File: rtl/dcache_wb_if.sv
// CPU-side and memory-side signal bundle for the write-back data cache.
// The cache connects through the slave modport. The CPU/memory side connects through the master modport.
interface dcache_wb_if #(
  parameter int DATA_WID = 32,
  parameter int LDST_WID = 3
);
  logic                cpu_req;
  logic [DATA_WID-1:0] addr;
  logic [LDST_WID-1:0] ldst;
  logic [DATA_WID-1:0] wdata;
  logic [DATA_WID-1:0] rdata;
  logic                dcache_stall;
  logic                misalign;
  logic                mem_req;
  logic                mem_we;
  logic [DATA_WID-1:0] mem_addr;
  logic [DATA_WID-1:0] mem_wdata;
  logic [DATA_WID-1:0] mem_rdata;
  logic                mem_ack;

  modport slave (
    input  cpu_req, addr, ldst, wdata, mem_rdata, mem_ack,
    output rdata, dcache_stall, misalign, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, addr, ldst, wdata, mem_rdata, mem_ack,
    input  rdata, dcache_stall, misalign, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with multi-word lines.
// Misses evict a dirty victim first, then refill the line one word at a time over a req/ack handshake.
module dcache_wb #(
  parameter int INDEX_BITS  = 8,
  parameter int OFFSET_BITS = 2
) (
  input logic        clk,
  input logic        rst_n,
  dcache_wb_if.slave bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;
  localparam int TAG_W = 30 - INDEX_BITS - OFFSET_BITS;
  localparam int CNT_W = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;

  localparam logic [2:0] LW_OP  = 3'd0;
  localparam logic [2:0] LH_OP  = 3'd1;
  localparam logic [2:0] LHU_OP = 3'd2;
  localparam logic [2:0] LB_OP  = 3'd3;
  localparam logic [2:0] LBU_OP = 3'd4;
  localparam logic [2:0] SW_OP  = 3'd5;
  localparam logic [2:0] SH_OP  = 3'd6;
  localparam logic [2:0] SB_OP  = 3'd7;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LINES-1:0]        valid_q, dirty_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [31:0]             data_q [LINES][WORDS];

  logic [TAG_W-1:0]        reqTag, memTag;
  logic [INDEX_BITS-1:0]   reqIdx;
  logic [CNT_W-1:0]        reqWord;
  logic                    isWord, isHalf, isStore, hit, storeHit, lastWord;
  logic                    fillWe, fillDone;
  logic [31:0]             curWord, mergedWord, storeData;
  logic [3:0]              byteEn;
  logic [7:0]              laneByte;
  logic [15:0]             laneHalf;

  // Masking the word select keeps single-word lines (OFFSET_BITS=0) pinned to word 0.
  assign reqWord  = CNT_W'(bus.addr >> 2) & CNT_W'(WORDS - 1);
  assign reqIdx   = INDEX_BITS'(bus.addr >> (2 + OFFSET_BITS));
  assign reqTag   = TAG_W'(bus.addr >> (2 + OFFSET_BITS + INDEX_BITS));
  assign curWord  = data_q[reqIdx][reqWord];
  assign lastWord = (cnt_q == CNT_W'(WORDS - 1));

  assign isWord  = (bus.ldst == LW_OP) || (bus.ldst == SW_OP);
  assign isHalf  = (bus.ldst == LH_OP) || (bus.ldst == LHU_OP) || (bus.ldst == SH_OP);
  assign isStore = (bus.ldst == SW_OP) || (bus.ldst == SH_OP) || (bus.ldst == SB_OP);

  assign bus.misalign = bus.cpu_req &&
                        ((isWord && (bus.addr[1:0] != 2'b00)) || (isHalf && bus.addr[0]));
  assign hit = bus.cpu_req && valid_q[reqIdx] && (tag_q[reqIdx] == reqTag) &&
               !bus.misalign && (state_q == IDLE);
  assign storeHit = hit && isStore;
  assign bus.dcache_stall = (state_q != IDLE) || (bus.cpu_req && !bus.misalign && !hit);

  assign laneByte = 8'(curWord >> {bus.addr[1:0], 3'b000});
  assign laneHalf = 16'(curWord >> {bus.addr[1], 4'b0000});

  always_comb begin
    bus.rdata = '0;
    if (hit && !isStore) begin
      case (bus.ldst)
        LW_OP:   bus.rdata = curWord;
        LH_OP:   bus.rdata = {{16{laneHalf[15]}}, laneHalf};
        LHU_OP:  bus.rdata = {16'h0000, laneHalf};
        LB_OP:   bus.rdata = {{24{laneByte[7]}}, laneByte};
        LBU_OP:  bus.rdata = {24'h000000, laneByte};
        default: bus.rdata = '0;
      endcase
    end
  end

  // Replicating the store data lets the byte enables alone pick the lanes.
  always_comb begin
    byteEn    = 4'b0000;
    storeData = bus.wdata;
    case (bus.ldst)
      SW_OP: byteEn = 4'b1111;
      SH_OP: begin
        byteEn    = bus.addr[1] ? 4'b1100 : 4'b0011;
        storeData = {2{bus.wdata[15:0]}};
      end
      SB_OP: begin
        byteEn    = 4'b0001 << bus.addr[1:0];
        storeData = {4{bus.wdata[7:0]}};
      end
      default: byteEn = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      mergedWord[8*i +: 8] = byteEn[i] ? storeData[8*i +: 8] : curWord[8*i +: 8];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fillWe        = 1'b0;
    fillDone      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    memTag        = reqTag;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.cpu_req && !bus.misalign && !hit) begin
          state_d = (valid_q[reqIdx] && dirty_q[reqIdx]) ? WB : FILL;
        end
      end
      WB: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = data_q[reqIdx][cnt_q];
        memTag        = tag_q[reqIdx];
        if (bus.mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (lastWord) begin
            cnt_d   = '0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          fillWe = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (lastWord) begin
            cnt_d    = '0;
            fillDone = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    bus.mem_addr = (32'(memTag) << (2 + OFFSET_BITS + INDEX_BITS)) |
                   (32'(reqIdx) << (2 + OFFSET_BITS)) |
                   (32'(cnt_q) << 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fillDone) begin
        valid_q[reqIdx] <= 1'b1;
        dirty_q[reqIdx] <= 1'b0;
      end else if (storeHit) begin
        dirty_q[reqIdx] <= 1'b1;
      end
    end
  end

  // Tags and data need no reset because the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fillWe) data_q[reqIdx][cnt_q] <= bus.mem_rdata;
    if (fillDone) tag_q[reqIdx] <= reqTag;
    if (storeHit) data_q[reqIdx][reqWord] <= mergedWord;
  end
endmodule

// File: tb/tb_dcache_wb.sv
// Scoreboard bench for dcache_wb: the stimulus pushes expected CPU responses and memory transfers.
// Negedge monitors pop those expectations and compare them whenever the DUT completes one.
module tb_dcache_wb;
  localparam logic [2:0] LW_OP  = 3'd0;
  localparam logic [2:0] LH_OP  = 3'd1;
  localparam logic [2:0] LHU_OP = 3'd2;
  localparam logic [2:0] LB_OP  = 3'd3;
  localparam logic [2:0] LBU_OP = 3'd4;
  localparam logic [2:0] SW_OP  = 3'd5;
  localparam logic [2:0] SH_OP  = 3'd6;
  localparam logic [2:0] SB_OP  = 3'd7;

  typedef struct {logic [31:0] rdata; logic mis;} cpuExp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} memExp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic memInit = 1'b1;
  int   ackDelay = 0;
  int   waitCnt = 0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] memory [0:4095];
  cpuExp_t expCpu[$];
  memExp_t expMem[$];
  cpuExp_t ce;
  memExp_t me;

  dcache_wb_if bus ();

  dcache_wb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = memory[bus.mem_addr[13:2]];
  assign bus.mem_ack   = bus.mem_req && (waitCnt >= ackDelay);

  // Zero- or fixed-wait memory: the line at 0x1000/0x2000/0x3000 holds 0x11111111 * (1..12).
  always @(posedge clk) begin
    if (memInit) begin
      for (int k = 0; k < 4; k++) begin
        memory[12'h400 + k] <= 32'h11111111 * (k + 1);
        memory[12'h800 + k] <= 32'h11111111 * (k + 5);
        memory[12'hC00 + k] <= 32'h11111111 * (k + 9);
      end
    end else if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
      memory[bus.mem_addr[13:2]] <= bus.mem_wdata;
    end
    if (!bus.mem_req || bus.mem_ack) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory-side monitor: each accepted word must match the next expected transfer.
  always @(negedge clk) begin
    if (rst_n && bus.mem_req && bus.mem_ack) begin
      if (expMem.size() == 0) begin
        checkOutput("memUnexpected", bus.mem_addr, 32'hFFFF_FFFF);
      end else begin
        me = expMem.pop_front();
        checkOutput("memWe", 32'(bus.mem_we), 32'(me.we));
        checkOutput("memAddr", bus.mem_addr, me.addr);
        if (me.we) checkOutput("memWdata", bus.mem_wdata, me.data);
      end
    end
  end

  // CPU-side monitor: an access completes in the first cycle it is not stalled.
  always @(negedge clk) begin
    if (rst_n && bus.cpu_req && !bus.dcache_stall) begin
      if (expCpu.size() == 0) begin
        checkOutput("cpuUnexpected", bus.rdata, 32'hFFFF_FFFF);
      end else begin
        ce = expCpu.pop_front();
        checkOutput("rdata", bus.rdata, ce.rdata);
        checkOutput("misalign", 32'(bus.misalign), 32'(ce.mis));
        checkOutput("memReqIdle", 32'(bus.mem_req), 32'd0);
      end
    end
  end

  task automatic expectWords(input logic we, input logic [31:0] base, input logic [31:0] d0,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    expMem.push_back('{we, base,        d0});
    expMem.push_back('{we, base + 32'd4,  d1});
    expMem.push_back('{we, base + 32'd8,  d2});
    expMem.push_back('{we, base + 32'd12, d3});
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] expR, input logic expMis, input int expStall);
    int  stalls;
    bit  done;
    expCpu.push_back('{expR, expMis});
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b1;
    bus.addr    = a;
    bus.ldst    = op;
    bus.wdata   = wd;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (!bus.dcache_stall) done = 1'b1;
      else stalls++;
    end
    if (!done) checkOutput("accessTimeout", 32'd0, 32'd1);
    checkOutput("stallCycles", 32'(stalls), 32'(expStall));
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.cpu_req = 1'b0;
    bus.addr    = '0;
    bus.ldst    = LW_OP;
    bus.wdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstMemReq", 32'(bus.mem_req), 32'd0);
    checkOutput("rstMemWe", 32'(bus.mem_we), 32'd0);
    checkOutput("rstStall", 32'(bus.dcache_stall), 32'd0);
    checkOutput("rstMisalign", 32'(bus.misalign), 32'd0);
    checkOutput("rstRdata", bus.rdata, 32'd0);
    memInit = 1'b0;
    rst_n   = 1'b1;

    expectWords(1'b0, 32'h1000, 0, 0, 0, 0);
    applyStimulus(LW_OP, 32'h1000, 0, 32'h1111_1111, 1'b0, 5);
    applyStimulus(SW_OP, 32'h1004, 32'h80FF_0000, 32'h0, 1'b0, 0);
    applyStimulus(LB_OP,  32'h1007, 0, 32'hFFFF_FF80, 1'b0, 0);
    applyStimulus(LBU_OP, 32'h1007, 0, 32'h0000_0080, 1'b0, 0);
    applyStimulus(LH_OP,  32'h1006, 0, 32'hFFFF_80FF, 1'b0, 0);
    applyStimulus(LHU_OP, 32'h1006, 0, 32'h0000_80FF, 1'b0, 0);
    applyStimulus(LW_OP,  32'h100C, 0, 32'h4444_4444, 1'b0, 0);
    applyStimulus(SB_OP,  32'h1001, 32'h0000_00AB, 32'h0, 1'b0, 0);
    applyStimulus(LW_OP,  32'h1000, 0, 32'h1111_AB11, 1'b0, 0);
    applyStimulus(LB_OP,  32'h1001, 0, 32'hFFFF_FFAB, 1'b0, 0);
    applyStimulus(LB_OP,  32'h1003, 0, 32'h0000_0011, 1'b0, 0);
    applyStimulus(SH_OP,  32'h100A, 32'h0000_BEEF, 32'h0, 1'b0, 0);
    applyStimulus(LW_OP,  32'h1008, 0, 32'hBEEF_3333, 1'b0, 0);

    applyStimulus(LW_OP, 32'h1002, 0, 32'h0, 1'b1, 0);
    applyStimulus(LH_OP, 32'h1003, 0, 32'h0, 1'b1, 0);
    applyStimulus(SW_OP, 32'h1001, 32'hDEAD_BEEF, 32'h0, 1'b1, 0);
    applyStimulus(LW_OP, 32'h1000, 0, 32'h1111_AB11, 1'b0, 0);

    expectWords(1'b1, 32'h1000, 32'h1111_AB11, 32'h80FF_0000, 32'hBEEF_3333, 32'h4444_4444);
    expectWords(1'b0, 32'h2000, 0, 0, 0, 0);
    applyStimulus(LW_OP, 32'h2000, 0, 32'h5555_5555, 1'b0, 9);
    applyStimulus(LBU_OP, 32'h200E, 0, 32'h0000_0088, 1'b0, 0);

    ackDelay = 1;
    expectWords(1'b0, 32'h1000, 0, 0, 0, 0);
    applyStimulus(LW_OP, 32'h1004, 0, 32'h80FF_0000, 1'b0, 9);
    ackDelay = 0;

    expMem.push_back('{1'b0, 32'h3000, 32'h0});
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b1;
    bus.addr    = 32'h3000;
    bus.ldst    = LW_OP;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("fillReqBeforeReset", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("memReqOnReset", 32'(bus.mem_req), 32'd0);
    bus.cpu_req = 1'b0;
    #1;
    checkOutput("stallInReset", 32'(bus.dcache_stall), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expectWords(1'b0, 32'h3000, 0, 0, 0, 0);
    applyStimulus(LW_OP, 32'h3000, 0, 32'h9999_9999, 1'b0, 5);
    applyStimulus(LW_OP, 32'h300C, 0, 32'hCCCC_CCCC, 1'b0, 0);

    repeat (2) @(posedge clk);
    checkOutput("memQueueLeft", 32'(expMem.size()), 32'd0);
    checkOutput("cpuQueueLeft", 32'(expCpu.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
